// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encoding and frame constants for the instruction memory loader
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_WAIT   = 3'd0,
    ST_CNT_HI = 3'd1,
    ST_CNT_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHK    = 3'd4,
    ST_RUN    = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  localparam logic [7:0] SYNC_BYTE      = 8'hA5;
  localparam int         BYTES_PER_WORD = 4;
  localparam int         CNT_W          = 16;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - big-endian byte-to-word assembler with running XOR checksum
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid,
  output logic [7:0]  chk
);

  logic [23:0] shift_q, shift_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  chk_q, chk_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      idx_q   <= '0;
      chk_q   <= '0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
      chk_q   <= chk_d;
    end
  end

  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    chk_d   = chk_q;
    if (clear) begin
      shift_d = '0;
      idx_d   = '0;
      chk_d   = '0;
    end else if (byte_valid) begin
      shift_d = {shift_q[15:0], byte_data};
      idx_d   = idx_q + 2'd1;
      chk_d   = chk_q ^ byte_data;
    end
  end

  // The word completes with the byte arriving now; the parent registers it.
  assign word       = {shift_q, byte_data};
  assign word_valid = byte_valid && !clear && (idx_q == 2'(BYTES_PER_WORD - 1));
  assign chk        = chk_q;

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - UART boot loader: frames bytes into words, writes instruction RAM, gates CPU reset
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int BOOT_WAIT    = 50000000,
  parameter int BYTE_TIMEOUT = 500000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  state_t              state_q, state_d;
  logic [31:0]         boot_cnt_q, boot_cnt_d;
  logic [31:0]         idle_q, idle_d;
  logic [CNT_W-1:0]    n_q, n_d;
  logic [CNT_W-1:0]    words_q, words_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic                pk_clear, pk_valid, word_valid;
  logic [31:0]         word;
  logic [7:0]          chk;
  logic [CNT_W-1:0]    n_full;
  logic                timeout, last_word;

  assign pk_clear  = start || (state_q inside {ST_WAIT, ST_CNT_HI, ST_CNT_LO});
  assign pk_valid  = rx_valid && !start && (state_q == ST_DATA);
  assign n_full    = {n_q[CNT_W-1:8], rx_data};
  assign timeout   = !rx_valid && (idle_q == 32'(BYTE_TIMEOUT - 1));
  assign last_word = (words_q + 16'd1) == n_q;

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (pk_clear),
    .byte_valid (pk_valid),
    .byte_data  (rx_data),
    .word       (word),
    .word_valid (word_valid),
    .chk        (chk)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_WAIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_WAIT;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (rx_valid && rx_data == SYNC_BYTE)               state_d = ST_CNT_HI;
          else if (boot_cnt_q == 32'(BOOT_WAIT - 1))          state_d = ST_RUN;
        end
        ST_CNT_HI: begin
          if (rx_valid)     state_d = ST_CNT_LO;
          else if (timeout) state_d = ST_ERR;
        end
        ST_CNT_LO: begin
          if (rx_valid) begin
            if (32'(n_full) > DEPTH) state_d = ST_ERR;
            else if (n_full == '0)   state_d = ST_CHK;
            else                     state_d = ST_DATA;
          end else if (timeout) begin
            state_d = ST_ERR;
          end
        end
        ST_DATA: begin
          if (word_valid && last_word) state_d = ST_CHK;
          else if (timeout)            state_d = ST_ERR;
        end
        ST_CHK: begin
          if (rx_valid)     state_d = (rx_data == chk) ? ST_RUN : ST_ERR;
          else if (timeout) state_d = ST_ERR;
        end
        ST_RUN:  state_d = ST_RUN;
        ST_ERR:  state_d = ST_ERR;
        default: state_d = ST_ERR;
      endcase
    end
  end

  always_comb begin
    boot_cnt_d  = (!start && state_q == ST_WAIT && state_d == ST_WAIT) ? boot_cnt_q + 32'd1 : '0;
    idle_d      = (start || rx_valid || (state_q inside {ST_WAIT, ST_RUN, ST_ERR})) ? '0 : idle_q + 32'd1;
    n_d         = n_q;
    if (!start && rx_valid && state_q == ST_CNT_HI) n_d = {rx_data, 8'h00};
    if (!start && rx_valid && state_q == ST_CNT_LO) n_d = n_full;
    words_d     = (start || state_q != ST_DATA) ? '0 : (word_valid ? words_q + 16'd1 : words_q);
    mem_we_d    = word_valid;
    mem_wdata_d = word_valid ? word : mem_wdata_q;
    // Address advances the cycle after each write pulse, so a pulse always uses the current value.
    if (start || (state_q inside {ST_WAIT, ST_CNT_HI, ST_CNT_LO})) mem_addr_d = '0;
    else if (mem_we_q)                                            mem_addr_d = mem_addr_q + ADDR_W'(1);
    else                                                          mem_addr_d = mem_addr_q;
    cpu_hold_d  = (state_d != ST_RUN);
    done_d      = done_q;
    error_d     = error_q;
    if (start) begin
      done_d  = 1'b0;
      error_d = 1'b0;
    end else if (state_d == ST_ERR && state_q != ST_ERR) begin
      done_d  = 1'b0;
      error_d = 1'b1;
    end else if (state_q == ST_CHK && state_d == ST_RUN) begin
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      boot_cnt_q  <= '0;
      idle_q      <= '0;
      n_q         <= '0;
      words_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      boot_cnt_q  <= boot_cnt_d;
      idle_q      <= idle_d;
      n_q         <= n_d;
      words_q     <= words_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule
